// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch unit and the controller.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Output register holding one fetched instruction for the decoder.
// Latency: load visible the cycle after load=1; clear drops valid the cycle after clear=1.
// Backpressure: holds contents indefinitely while neither load nor clear is asserted.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  fetch_entry_t load_entry,
    output fetch_entry_t entry,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= '0;
            valid <= 1'b0;
        end else if (load) begin
            entry <= load_entry;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, redirect-aware, single-entry output buffer.
// Latency: request to instr_valid = accept cycle + response cycle; next request after consume.
// Backpressure: stalls in HOLD with imem_req low until the decoder takes the instruction.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  fetch_pc_next;
    logic         buf_load;
    logic         buf_clear;
    fetch_entry_t buf_in;
    fetch_entry_t buf_out;

    assign fetch_pc_next = fetch_pc + 32'd4;

    // A redirect coinciding with a response kills that response.
    assign buf_load  = (state == FETCH_WAIT) && imem_rvalid && !pc_src;
    assign buf_clear = (state == FETCH_HOLD) && (instr_ready || pc_src);

    assign buf_in = '{instr: imem_rdata, pc: fetch_pc, pc_plus4: fetch_pc_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH_REQ;
            fetch_pc   <= RESET_PC_ALIGNED;
            misaligned <= 1'b0;
        end else begin
            misaligned <= pc_src && (pc_target[1:0] != 2'b00);
            if (pc_src) begin
                fetch_pc <= word_align(pc_target);
                case (state)
                    FETCH_REQ:  state <= imem_ready  ? FETCH_DROP : FETCH_REQ;
                    FETCH_WAIT: state <= imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                    FETCH_DROP: state <= imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                    FETCH_HOLD: state <= FETCH_REQ;
                    default:    state <= FETCH_REQ;
                endcase
            end else begin
                case (state)
                    FETCH_REQ: begin
                        if (imem_ready) state <= FETCH_WAIT;
                    end
                    FETCH_WAIT: begin
                        if (imem_rvalid) begin
                            fetch_pc <= fetch_pc_next;
                            state    <= FETCH_HOLD;
                        end
                    end
                    FETCH_DROP: begin
                        if (imem_rvalid) state <= FETCH_REQ;
                    end
                    FETCH_HOLD: begin
                        if (instr_ready) state <= FETCH_REQ;
                    end
                    default: state <= FETCH_REQ;
                endcase
            end
        end
    end

    // Request is gated by reset so nothing leaves the unit while it is held.
    assign imem_req  = (state == FETCH_REQ) && !rst;
    assign imem_addr = fetch_pc;

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_entry (buf_in),
        .entry      (buf_out),
        .valid      (instr_valid)
    );

    assign instr    = buf_out.instr;
    assign pc       = buf_out.pc;
    assign pc_plus4 = buf_out.pc_plus4;
    assign op       = buf_out.instr[6:0];
    assign funct3   = buf_out.instr[14:12];
    assign funct7   = buf_out.instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance covers the wrapping reset PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_ready;

    logic        imem_req,    imem_req2;
    logic [31:0] imem_addr,   imem_addr2;
    logic        instr_valid, instr_valid2;
    logic [31:0] instr,       instr2;
    logic [6:0]  op,          op2;
    logic [2:0]  funct3,      funct3_2;
    logic        funct7,      funct7_2;
    logic [31:0] pc,          pc2;
    logic [31:0] pc_plus4,    pc_plus4_2;
    logic        misaligned,  misaligned2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .op(op), .funct3(funct3), .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4),
        .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid2), .instr_ready(instr_ready), .instr(instr2),
        .op(op2), .funct3(funct3_2), .funct7(funct7_2), .pc(pc2), .pc_plus4(pc_plus4_2),
        .misaligned(misaligned2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_src      = 1'b0;
        pc_target   = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        repeat (3) tick();
        n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr); else n_pass++;
        n_total++; if (pc !== 32'h0 || pc_plus4 !== 32'h0) $display("FAIL rst_pc: got %h/%h want 0/0", pc, pc_plus4); else n_pass++;
        n_total++; if (misaligned !== 1'b0) $display("FAIL rst_misaligned: got %b want 0", misaligned); else n_pass++;
        n_total++; if (imem_req2 !== 1'b0) $display("FAIL rst_req2: got %b want 0", imem_req2); else n_pass++;
        idle_inputs();
        rst = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rel_req: got %b/%h want 1/00000000", imem_req, imem_addr); else n_pass++;
        n_total++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) $display("FAIL rel_req2: got %b/%h want 1/fffffffc", imem_req2, imem_addr2); else n_pass++;
    endtask

    task automatic test_first_fetch();
        do_reset();
        imem_ready = 1'b1;
        tick();
        n_total++; if (imem_req !== 1'b0) $display("FAIL ff_wait_req: got %b want 0", imem_req); else n_pass++;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b1) $display("FAIL ff_valid: got %b want 1", instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0050_0093) $display("FAIL ff_instr: got %h want 00500093", instr); else n_pass++;
        n_total++; if (op !== 7'b0010011 || funct3 !== 3'd0 || funct7 !== 1'b0) $display("FAIL ff_fields: got %b/%0d/%b want 0010011/0/0", op, funct3, funct7); else n_pass++;
        n_total++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) $display("FAIL ff_pc: got %h/%h want 0/4", pc, pc_plus4); else n_pass++;
        n_total++; if (pc2 !== 32'hFFFF_FFFC || pc_plus4_2 !== 32'h0) $display("FAIL wrap_pc: got %h/%h want fffffffc/0", pc2, pc_plus4_2); else n_pass++;
        n_total++; if (instr2 !== 32'h0050_0093 || op2 !== 7'b0010011 || funct3_2 !== 3'd0 || funct7_2 !== 1'b0 || instr_valid2 !== 1'b1)
            $display("FAIL wrap_instr: got %h/%b valid %b want 00500093/0010011 valid 1", instr2, op2, instr_valid2); else n_pass++;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL ff_consume: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL ff_next: got %b/%h want 1/00000004", imem_req, imem_addr); else n_pass++;
        n_total++; if (imem_addr2 !== 32'h0 || misaligned2 !== 1'b0) $display("FAIL wrap_next: got %h/%b want 00000000/0", imem_addr2, misaligned2); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data = 32'h1000_0013 + 32'(k) * 32'h0010_0000;
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) $display("FAIL b2b_addr%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, 32'(4 * k)); else n_pass++;
            imem_ready = 1'b1;
            tick();
            imem_ready = 1'b1;
            n_total++; if (imem_req !== 1'b0) $display("FAIL b2b_outst%0d: got %b want 0", k, imem_req); else n_pass++;
            tick();
            imem_ready = 1'b0;
            n_total++; if (imem_req !== 1'b0) $display("FAIL b2b_outst2_%0d: got %b want 0", k, imem_req); else n_pass++;
            imem_rvalid = 1'b1;
            imem_rdata  = data;
            tick();
            imem_rvalid = 1'b0;
            n_total++; if (instr_valid !== 1'b1 || instr !== data || pc !== 32'(4 * k))
                $display("FAIL b2b_out%0d: got %b/%h/%h want 1/%h/%h", k, instr_valid, instr, pc, data, 32'(4 * k)); else n_pass++;
            tick();
        end
        instr_ready = 1'b0;
        n_total++; if (imem_addr !== 32'hC) $display("FAIL b2b_final: got %h want 0000000c", imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        pc_src     = 1'b1;
        pc_target  = 32'h100;
        tick();
        pc_src = 1'b0;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rw_drop_req: got %b want 0", imem_req); else n_pass++;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rw_dropped: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL rw_addr: got %b/%h want 1/00000100", imem_req, imem_addr); else n_pass++;
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        pc_src      = 1'b1;
        pc_target   = 32'h200;
        imem_rvalid = 1'b1;
        tick();
        pc_src      = 1'b0;
        imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rw_same_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rw_same_addr: got %b/%h want 1/00000200", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_hold_stall();
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 2);
            imem_rdata  = 32'hAAAA_5555;
            tick();
            n_total++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || pc !== 32'h0 || imem_req !== 1'b0)
                $display("FAIL hold%0d: got %b/%h/%h/req %b want 1/12345678/0/req 0", i, instr_valid, instr, pc, imem_req); else n_pass++;
        end
        imem_rvalid = 1'b0;
        pc_src      = 1'b1;
        pc_target   = 32'h40;
        instr_ready = 1'b1;
        tick();
        pc_src      = 1'b0;
        instr_ready = 1'b0;
        n_total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40)
            $display("FAIL hold_redir: got %b/%b/%h want 0/1/00000040", instr_valid, imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset();
        pc_src    = 1'b1;
        pc_target = 32'h103;
        tick();
        pc_src = 1'b0;
        n_total++; if (misaligned !== 1'b1) $display("FAIL mis_pulse: got %b want 1", misaligned); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL mis_addr: got %b/%h want 1/00000100", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if (misaligned !== 1'b0) $display("FAIL mis_width: got %b want 0", misaligned); else n_pass++;
        pc_src    = 1'b1;
        pc_target = 32'h200;
        tick();
        pc_src = 1'b0;
        n_total++; if (misaligned !== 1'b0 || imem_addr !== 32'h200) $display("FAIL mis_aligned: got %b/%h want 0/00000200", misaligned, imem_addr); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0BAD;
        tick();
        imem_rvalid = 1'b0;
        n_total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL rst_mid: got %b/%b/%h want 0/1/00000000", instr_valid, imem_req, imem_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_redirect_wait();
        test_hold_stall();
        test_misaligned();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
